// File: rtl/pool_window_gen.sv
// rtl/pool_window_gen.sv - streaming 2x2 stride-2 window generator for average pooling
//
// Accepts one pixel per cycle in row-major order, buffers one row, and emits each
// non-overlapping 2x2 window as four parallel words. Pixel data is passed bit-exact.
//
// Ports:
//   clk         - single clock, rising edge
//   reset       - synchronous, active-high; has priority over pix_valid
//   pix_in      - incoming pixel word
//   pix_valid   - pix_in accepted on every cycle this is high (no backpressure)
//   numA..numD  - window top-left, top-right, bottom-left, bottom-right
//   win_valid   - one-cycle pulse, numA..numD hold a complete window
//   win_col     - output column index of the current window
//   win_row     - output row index of the current window
//   frame_last  - high with win_valid on the final window of a frame

module pool_window_gen #(
   parameter int DATA_WIDTH = 16,
   parameter int IMG_WIDTH  = 24,
   parameter int IMG_HEIGHT = 24,
   localparam int COL_W = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1,
   localparam int ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1,
   localparam int WC_W  = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH / 2)  : 1,
   localparam int WR_W  = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT / 2) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] pix_in,
   input  logic                  pix_valid,
   output logic [DATA_WIDTH-1:0] numA,
   output logic [DATA_WIDTH-1:0] numB,
   output logic [DATA_WIDTH-1:0] numC,
   output logic [DATA_WIDTH-1:0] numD,
   output logic                  win_valid,
   output logic [WC_W-1:0]       win_col,
   output logic [WR_W-1:0]       win_row,
   output logic                  frame_last
);

   logic [COL_W-1:0]      col;
   logic [ROW_W-1:0]      row;
   logic [DATA_WIDTH-1:0] hold;
   logic [DATA_WIDTH-1:0] linebuf [IMG_WIDTH];

   logic             col_last;
   logic             row_last;
   logic             assemble;
   logic [COL_W-1:0] col_even;

   assign col_last = (col == COL_W'(IMG_WIDTH - 1));
   assign row_last = (row == ROW_W'(IMG_HEIGHT - 1));
   // Phase comes straight from the counter parities: odd row, odd column closes a window.
   assign assemble = pix_valid & row[0] & col[0];
   // Left column of the window being closed (col is odd here).
   assign col_even = col & ~COL_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         col        <= '0;
         row        <= '0;
         hold       <= '0;
         numA       <= '0;
         numB       <= '0;
         numC       <= '0;
         numD       <= '0;
         win_valid  <= 1'b0;
         win_col    <= '0;
         win_row    <= '0;
         frame_last <= 1'b0;
      end else begin
         win_valid  <= assemble;
         frame_last <= assemble & row_last & col_last;
         if (pix_valid) begin
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + ROW_W'(1);
            end else begin
               col <= col + COL_W'(1);
            end
            if (row[0] && !col[0]) begin
               hold <= pix_in;
            end
         end
         if (assemble) begin
            numA    <= linebuf[col_even];
            numB    <= linebuf[col];
            numC    <= hold;
            numD    <= pix_in;
            win_col <= WC_W'(col >> 1);
            win_row <= WR_W'(row >> 1);
         end
      end
   end

   // Line buffer is not reset: every entry is rewritten on an even row before the
   // following odd row reads it.
   always_ff @(posedge clk) begin
      if (!reset && pix_valid && !row[0]) begin
         linebuf[col] <= pix_in;
      end
   end

endmodule

// File: tb/tb_pool_window_gen.sv
// tb/tb_pool_window_gen.sv - directed self-checking bench for pool_window_gen
module tb_pool_window_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel;
   logic [15:0] px_s, px_d;
   logic        pv_s, pv_d;

   logic [15:0] s_a, s_b, s_c, s_d, d_a, d_b, d_c, d_d;
   logic        s_v, d_v, s_fl, d_fl;
   logic [0:0]  s_col, s_row;
   logic [3:0]  d_col, d_row;

   logic [15:0] o_a, o_b, o_c, o_d;
   logic        o_v, o_fl;
   logic [7:0]  o_col, o_row;

   logic [15:0] pix [576];
   logic [15:0] exp_a, exp_b, exp_c, exp_d;
   logic [7:0]  exp_col, exp_row;

   int npass = 0;
   int nfail = 0;
   int ntot  = 0;

   always #5 clk = ~clk;

   pool_window_gen #(.DATA_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_s (
      .clk(clk), .reset(reset), .pix_in(px_s), .pix_valid(pv_s),
      .numA(s_a), .numB(s_b), .numC(s_c), .numD(s_d),
      .win_valid(s_v), .win_col(s_col), .win_row(s_row), .frame_last(s_fl)
   );

   pool_window_gen dut_d (
      .clk(clk), .reset(reset), .pix_in(px_d), .pix_valid(pv_d),
      .numA(d_a), .numB(d_b), .numC(d_c), .numD(d_d),
      .win_valid(d_v), .win_col(d_col), .win_row(d_row), .frame_last(d_fl)
   );

   always_comb begin
      o_a   = sel ? d_a  : s_a;
      o_b   = sel ? d_b  : s_b;
      o_c   = sel ? d_c  : s_c;
      o_d   = sel ? d_d  : s_d;
      o_v   = sel ? d_v  : s_v;
      o_fl  = sel ? d_fl : s_fl;
      o_col = sel ? 8'(d_col) : 8'(s_col);
      o_row = sel ? 8'(d_row) : 8'(s_row);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      ntot++;
      assert (obs === expv) npass++;
      else begin
         nfail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_out(input logic v, input logic fl);
      chk("win_valid", 32'(o_v), 32'(v));
      chk("frame_last", 32'(o_fl), 32'(fl));
      chk("numA", 32'(o_a), 32'(exp_a));
      chk("numB", 32'(o_b), 32'(exp_b));
      chk("numC", 32'(o_c), 32'(exp_c));
      chk("numD", 32'(o_d), 32'(exp_d));
      chk("win_col", 32'(o_col), 32'(exp_col));
      chk("win_row", 32'(o_row), 32'(exp_row));
   endtask

   task automatic step(input logic v, input logic [15:0] d);
      if (sel) begin
         pv_d = v; px_d = d; pv_s = 1'b0;
      end else begin
         pv_s = v; px_s = d; pv_d = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   // Streams pix[0 .. w*h-1]; expected windows are taken from the pixel array by position.
   task automatic run_frame(input int w, input int h, input bit gaps);
      int  nwin;
      int  r, c, g;
      bit  win, last;
      nwin = 0;
      for (int i = 0; i < w * h; i++) begin
         if (gaps) begin
            g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) begin
               step(1'b0, 16'hdead);
               chk_out(1'b0, 1'b0);
            end
         end
         step(1'b1, pix[i]);
         r = i / w;
         c = i % w;
         win  = (r % 2 == 1) && (c % 2 == 1);
         last = win && (r == h - 1) && (c == w - 1);
         if (win) begin
            exp_a   = pix[(r - 1) * w + c - 1];
            exp_b   = pix[(r - 1) * w + c];
            exp_c   = pix[r * w + c - 1];
            exp_d   = pix[r * w + c];
            exp_col = 8'(c / 2);
            exp_row = 8'(r / 2);
         end
         chk_out(win, last);
         if (o_v) nwin++;
      end
      chk("win_count", 32'(nwin), 32'(w * h / 4));
   endtask

   task automatic clear_exp();
      exp_a = '0; exp_b = '0; exp_c = '0; exp_d = '0;
      exp_col = '0; exp_row = '0;
   endtask

   initial begin
      reset = 1'b1;
      sel = 1'b0;
      pv_s = 1'b0; pv_d = 1'b0; px_s = '0; px_d = '0;
      clear_exp();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // reset state of both instances
      chk_out(1'b0, 1'b0);
      sel = 1'b1;
      #1;
      chk_out(1'b0, 1'b0);
      sel = 1'b0;
      #1;

      // basic 4x4 frame, back-to-back
      for (int i = 0; i < 16; i++) pix[i] = 16'(i + 1);
      run_frame(4, 4, 1'b0);
      chk("basic_hold_A", 32'(o_a), 32'h000B);
      chk("basic_hold_B", 32'(o_b), 32'h000C);
      chk("basic_hold_C", 32'(o_c), 32'h000F);
      chk("basic_hold_D", 32'(o_d), 32'h0010);

      // gapped input, same frame
      run_frame(4, 4, 1'b1);

      // two frames back-to-back, second starts with no idle cycle
      run_frame(4, 4, 1'b0);
      for (int i = 0; i < 16; i++) pix[i] = 16'(16'h0101 + i);
      run_frame(4, 4, 1'b0);
      chk("b2b_hold_A", 32'(o_a), 32'h010B);
      chk("b2b_hold_D", 32'(o_d), 32'h0110);

      // reset mid-frame after 7 pixels; reset asserted alongside the closing pixel
      for (int k = 1; k <= 7; k++) step(1'b1, 16'(k));
      reset = 1'b1;
      step(1'b1, 16'h0008);
      reset = 1'b0;
      clear_exp();
      chk_out(1'b0, 1'b0);
      step(1'b0, 16'h0000);
      chk_out(1'b0, 1'b0);
      for (int i = 0; i < 16; i++) pix[i] = 16'(16'h0201 + i);
      run_frame(4, 4, 1'b0);

      // half-precision special encodings pass through unchanged
      for (int i = 0; i < 16; i++) pix[i] = 16'(16'h3C00 + i);
      pix[2]  = 16'h7E00;
      pix[5]  = 16'h7C00;
      pix[8]  = 16'h8000;
      pix[15] = 16'hFC00;
      run_frame(4, 4, 1'b1);
      chk("pt_hold_D", 32'(o_d), 32'hFC00);

      // default 24x24 instance, incrementing values
      sel = 1'b1;
      clear_exp();
      #1;
      for (int i = 0; i < 576; i++) pix[i] = 16'(i + 1);
      run_frame(24, 24, 1'b0);
      chk("dflt_hold_A", 32'(o_a), 32'h0227);
      chk("dflt_hold_D", 32'(o_d), 32'h0240);
      chk("dflt_hold_col", 32'(o_col), 32'd11);
      chk("dflt_hold_row", 32'(o_row), 32'd11);
      step(1'b0, 16'h0000);
      chk("dflt_fl_drop", 32'(o_fl), 32'd0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
